// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner and its debounce/event logic.
package keypad_pkg;
  localparam int unsigned ROWS    = 4;
  localparam int unsigned COLS    = 4;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned FRAME_W = ROWS * COLS;

  typedef enum logic [1:0] {IDLE, PRESSED, WAIT_REL} kp_state_e;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} kp_class_e;

  function automatic kp_class_e classify(input logic [FRAME_W-1:0] f);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < FRAME_W; i++) n = n + 5'(f[i]);
    if (n == 5'd0)      return NONE;
    else if (n == 5'd1) return SINGLE;
    else                return MULTI;
  endfunction

  // Index of the highest set bit; only meaningful for SINGLE frames.
  function automatic logic [CODE_W-1:0] key_index(input logic [FRAME_W-1:0] f);
    logic [CODE_W-1:0] k;
    k = '0;
    for (int i = 0; i < FRAME_W; i++) if (f[i]) k = CODE_W'(i);
    return k;
  endfunction
endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce: counts identical consecutive frames and runs the press/release FSM.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 5
) (
  input  logic               clk_100MHz,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic               frame_done_i,
  output logic               key_valid_o,
  output logic [CODE_W-1:0]  key_code_o,
  output logic               key_held_o
);
  localparam logic [3:0] DB = 4'(DEBOUNCE_FRAMES);

  kp_state_e          state_q, state_d;
  logic [FRAME_W-1:0] prev_q, prev_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               valid_q, valid_d;
  logic               stable;
  kp_class_e          cls;
  logic [CODE_W-1:0]  k;

  always_comb begin
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    code_d  = code_q;
    valid_d = 1'b0;
    stable  = 1'b0;
    cls     = classify(frame_i);
    k       = key_index(frame_i);
    if (frame_done_i) begin
      prev_d = frame_i;
      if (frame_i != prev_q)  cnt_d = 4'd1;
      else if (cnt_q < DB)    cnt_d = cnt_q + 4'd1;
      // Acceptance uses the count including this frame, so the event lands one edge later.
      stable = (cnt_d == DB);
      case (state_q)
        IDLE: if (stable && cls == SINGLE) begin
          code_d  = k;
          valid_d = 1'b1;
          state_d = PRESSED;
        end
        PRESSED: if (stable) begin
          if (cls == NONE)                          state_d = IDLE;
          else if (cls == MULTI || k != code_q)     state_d = WAIT_REL;
        end
        WAIT_REL: if (stable && cls == NONE)        state_d = IDLE;
        default:                                    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign key_valid_o = valid_q;
  assign key_code_o  = code_q;
  assign key_held_o  = (state_q != IDLE);
endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: row drive, column sync, frame assembly, debounced key events.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 100000,
  parameter int unsigned DEBOUNCE_FRAMES = 5
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic [COLS-1:0]   key_col,
  output logic [ROWS-1:0]   key_row,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_held
);
  localparam int unsigned SLOT_W = $clog2(SCAN_DIV);

  logic [COLS-1:0]    sync1_q, sync2_q;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [1:0]         row_q, row_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               slot_end, frame_done;

  assign slot_end   = (slot_q == SLOT_W'(SCAN_DIV - 1));
  assign frame_done = slot_end && (row_q == 2'd3);

  // Columns are sampled on the last slot cycle only, giving the rows time to settle.
  always_comb begin
    slot_d  = slot_end ? '0 : slot_q + 1'b1;
    row_d   = slot_end ? row_q + 2'd1 : row_q;
    frame_d = frame_q;
    if (slot_end) frame_d[{row_q, 2'b00} +: COLS] = ~sync2_q;
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      slot_q  <= '0;
      row_q   <= '0;
      frame_q <= '0;
    end else begin
      sync1_q <= key_col;
      sync2_q <= sync1_q;
      slot_q  <= slot_d;
      row_q   <= row_d;
      frame_q <= frame_d;
    end
  end

  assign key_row = ~(4'b0001 << row_q);

  keypad_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_debounce (
    .clk_100MHz   (clk_100MHz),
    .rst          (rst),
    .frame_i      (frame_d),
    .frame_done_i (frame_done),
    .key_valid_o  (key_valid),
    .key_code_o   (key_code),
    .key_held_o   (key_held)
  );
endmodule

// File: tb/tb_keypad_scan.sv
// Keypad scanner bench: matrix emulation, frame-level reference model, directed and random phases.
module tb_keypad_scan;
  localparam int SD = 4, DB = 2, FRAME = 4 * SD;

  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  key_col, key_row, key_code;
  logic        key_valid, key_held;
  logic [15:0] pressed = 16'h0;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DB)) dut (
    .clk_100MHz(clk), .rst(rst), .key_col(key_col), .key_row(key_row),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held));

  // Physical matrix: a pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!key_row[r] && pressed[r*4+c]) key_col[c] = 1'b0;
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: works on whole frames (the pressed set held across each frame).
  int          cyc = 0;
  bit          armed = 0;
  logic [15:0] m_last;
  int          m_run, m_state;   // 0 idle, 1 pressed, 2 waiting for release
  logic        m_valid, m_held;
  logic [3:0]  m_code;

  task automatic step_frame(input logic [15:0] f);
    int n, k;
    m_run  = (f == m_last) ? m_run + 1 : 1;
    m_last = f;
    n = $countones(f);
    k = 0;
    for (int i = 0; i < 16; i++) if (f[i]) k = i;
    if (m_run >= DB) begin
      case (m_state)
        0: if (n == 1) begin m_code = 4'(k); m_valid = 1'b1; m_state = 1; end
        1: if (n == 0) m_state = 0;
           else if (n > 1 || k != int'(m_code)) m_state = 2;
        default: if (n == 0) m_state = 0;
      endcase
    end
    m_held = (m_state != 0);
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) begin
      cyc = 0; m_last = 16'h0; m_run = 0; m_state = 0;
      m_valid = 1'b0; m_code = 4'h0; m_held = 1'b0; armed = 1;
    end else begin
      m_valid = 1'b0;
      if (cyc % FRAME == FRAME - 1) step_frame(pressed);
      cyc++;
    end
  end

  int         ev_cyc[$];
  logic [3:0] ev_code[$];

  initial forever begin
    @(negedge clk);
    if (armed) begin
      logic [3:0] er;
      er = 4'hF;
      er[(cyc / SD) % 4] = 1'b0;
      check("key_row", 16'(key_row), 16'(er));
      check("key_valid", 16'(key_valid), 16'(m_valid));
      check("key_code", 16'(key_code), 16'(m_code));
      check("key_held", 16'(key_held), 16'(m_held));
      if (key_valid) begin ev_cyc.push_back(cyc); ev_code.push_back(key_code); end
    end
  end

  task automatic next_frame();
    int guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
      if (guard > 2 * FRAME) begin
        $display("FAIL frame_align: cycle counter stuck at %0d", cyc);
        $fatal(1, "frame alignment lost");
      end
    end while (cyc % FRAME != 0);
  endtask

  task automatic hold(input logic [15:0] p, input int nfr);
    pressed = p;
    repeat (nfr) next_frame();
  endtask

  task automatic check_events(input string nm, input int n, input logic [3:0] code);
    check({nm, "_count"}, 16'(ev_code.size()), 16'(n));
    if (n > 0 && ev_code.size() > 0) check({nm, "_code"}, 16'(ev_code[ev_code.size()-1]), 16'(code));
  endtask

  initial begin
    logic [15:0] p;
    pressed = 16'h0200;                // row 2, col 1 -> code 9
    repeat (3) @(posedge clk);
    #1;
    check("rst_row", 16'(key_row), 16'hE);
    check("rst_valid", 16'(key_valid), 16'h0);
    check("rst_code", 16'(key_code), 16'h0);
    check("rst_held", 16'(key_held), 16'h0);
    rst = 1'b0;

    hold(16'h0200, 3);
    check_events("held_from_reset", 1, 4'd9);
    if (ev_cyc.size() > 0) check("accept_cycle", 16'(ev_cyc[0]), 16'd32);
    check("held_after_accept", 16'(key_held), 16'h1);
    ev_code.delete(); ev_cyc.delete();

    hold(16'h0000, 3);
    check_events("release", 0, 4'd0);
    check("held_after_release", 16'(key_held), 16'h0);

    hold(16'h0200, 1); hold(16'h0000, 1); hold(16'h0200, 1); hold(16'h0000, 1);
    check_events("bounce_phase", 0, 4'd0);
    hold(16'h0200, 3);
    check_events("bounce_steady", 1, 4'd9);
    hold(16'h0000, 3);
    ev_code.delete(); ev_cyc.delete();

    hold(16'h8001, 5);
    check_events("multi", 0, 4'd0);
    check("multi_held", 16'(key_held), 16'h0);
    hold(16'h0001, 3);
    check_events("multi_to_single", 1, 4'd0);
    hold(16'h0000, 3);
    ev_code.delete(); ev_cyc.delete();

    hold(16'h0020, 3);
    check_events("roll_first", 1, 4'd5);
    hold(16'h0060, 3);
    hold(16'h0040, 3);
    check_events("roll_no_event", 1, 4'd5);
    check("roll_held", 16'(key_held), 16'h1);
    hold(16'h0000, 3);
    hold(16'h0040, 3);
    check_events("roll_repress", 2, 4'd6);
    hold(16'h0000, 3);
    ev_code.delete(); ev_cyc.delete();

    hold(16'h0200, 1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_row", 16'(key_row), 16'hE);
    check("midrst_valid", 16'(key_valid), 16'h0);
    check("midrst_code", 16'(key_code), 16'h0);
    check("midrst_held", 16'(key_held), 16'h0);
    check_events("midrst_no_event", 0, 4'd0);
    rst = 1'b0;
    hold(16'h0200, 3);
    check_events("midrst_reaccept", 1, 4'd9);
    if (ev_cyc.size() > 0) check("midrst_cycle", 16'(ev_cyc[0]), 16'd32);
    hold(16'h0000, 3);

    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 3))
        0:       p = 16'h0;
        1, 2:    p = 16'h1 << $urandom_range(0, 15);
        default: p = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      endcase
      hold(p, $urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
